// File: rtl/detarb_pkg.sv
// ============================================================================
// detarb_pkg
// Shared state encoding and hit-counter constants for detect_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

package detarb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } detarb_state_e;

    localparam int                     C_HIT_CNT_W   = 8;
    localparam logic [C_HIT_CNT_W-1:0] C_HIT_CNT_MAX = 8'd255;

endpackage

`default_nettype wire

// File: rtl/detect_arbiter_rr_pick.sv
// ============================================================================
// rr_pick
// Combinational round-robin selector: first requester after 'last', wrapping.
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import detarb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         pick,
    output logic [$clog2(NREQ)-1:0] pick_id
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] w_idx;
    logic           w_found;

    // Scan last+1, last+2, ... last+NREQ so the previous owner comes last.
    always_comb begin
        pick    = '0;
        pick_id = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = IDW'((int'(last) + i) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found       = 1'b1;
                pick[w_idx]   = 1'b1;
                pick_id       = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/detect_arbiter.sv
// ============================================================================
// detect_arbiter
// Round-robin sharing of one serial sequence detector among NREQ requesters.
// Optional hit counter enabled by defining DETARB_HIT_COUNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module detect_arbiter
    import detarb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int BURST = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          bit_in,
    input  logic                     det_z,
    output logic                     det_w,
    output logic                     det_reset,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     hit_valid,
    output logic [$clog2(NREQ)-1:0]  hit_id
`ifdef DETARB_HIT_COUNT_EN
    ,
    output logic [C_HIT_CNT_W-1:0]   hit_count
`endif
);

    localparam int             IDW        = $clog2(NREQ);
    localparam logic [7:0]     C_CNT_LAST = 8'(BURST - 1);
    localparam logic [IDW-1:0] C_LAST_RST = IDW'(NREQ - 1);

    detarb_state_e  r_state;
    detarb_state_e  w_state_nxt;
    logic [7:0]     r_cnt;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] r_hit_id;
    logic           r_hit_valid;
    logic           r_aborted;
    logic [NREQ-1:0] w_pick;
    logic [IDW-1:0] w_pick_id;
    logic           w_abort;
    logic           w_burst_end;
    logic           w_window;

    rr_pick #(
        .NREQ    (NREQ)
    ) u_rr_pick (
        .req     (req),
        .last    (r_last),
        .pick    (w_pick),
        .pick_id (w_pick_id)
    );

    always_comb begin
        w_abort     = (r_state == S_RUN) && !req[r_owner];
        w_burst_end = (r_state == S_RUN) && (r_cnt == C_CNT_LAST);
        // z lags the fed bit by one cycle; an aborted final bit is not reported.
        w_window    = ((r_state == S_RUN) && (r_cnt != 8'd0)) ||
                      ((r_state == S_RELEASE) && !r_aborted);
        w_state_nxt = r_state;
        grant       = '0;
        det_w       = 1'b0;
        det_reset   = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (|w_pick) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                det_reset   = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                grant[r_owner] = 1'b1;
                det_w          = bit_in[r_owner];
                if (w_abort || w_burst_end) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_owner     <= '0;
            r_last      <= C_LAST_RST;
            r_aborted   <= 1'b0;
            r_hit_valid <= 1'b0;
            r_hit_id    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hit_valid <= w_window & det_z;
            r_hit_id    <= r_owner;
            case (r_state)
                S_IDLE: begin
                    if (|w_pick) begin
                        r_owner <= w_pick_id;
                    end
                end
                S_CLEAR: begin
                    r_cnt     <= 8'd0;
                    r_aborted <= 1'b0;
                end
                S_RUN: begin
                    r_cnt     <= r_cnt + 8'd1;
                    r_aborted <= w_abort;
                end
                S_RELEASE: begin
                    r_last <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

    assign hit_valid = r_hit_valid;
    assign hit_id    = r_hit_id;

`ifdef DETARB_HIT_COUNT_EN
    logic [C_HIT_CNT_W-1:0] r_hit_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count <= '0;
        end else if (r_state == S_CLEAR) begin
            r_hit_count <= '0;
        end else if (r_hit_valid && (r_hit_count != C_HIT_CNT_MAX)) begin
            r_hit_count <= r_hit_count + 1'b1;
        end
    end

    assign hit_count = r_hit_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_detect_arbiter.sv
// ============================================================================
// tb_detect_arbiter
// Self-checking bench for detect_arbiter (NREQ=4, BURST=8).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_detect_arbiter;

    localparam int NREQ  = 4;
    localparam int BURST = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] bit_in = '0;
    logic       det_z = 1'b0;
    logic       det_w;
    logic       det_reset;
    logic [3:0] grant;
    logic       busy;
    logic       hit_valid;
    logic [1:0] hit_id;
`ifdef DETARB_HIT_COUNT_EN
    logic [7:0] hit_count;
`endif

    int checks = 0;
    int errors = 0;

    detect_arbiter #(
        .NREQ      (NREQ),
        .BURST     (BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .bit_in    (bit_in),
        .det_z     (det_z),
        .det_w     (det_w),
        .det_reset (det_reset),
        .grant     (grant),
        .busy      (busy),
        .hit_valid (hit_valid),
        .hit_id    (hit_id)
`ifdef DETARB_HIT_COUNT_EN
        ,
        .hit_count (hit_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        req    = '0;
        bit_in = '0;
        det_z  = 1'b0;
        repeat (2) begin
            tick();
            chk("rst_grant", grant, 0);
            chk("rst_det_w", det_w, 0);
            chk("rst_det_reset", det_reset, 0);
            chk("rst_busy", busy, 0);
            chk("rst_hit_valid", hit_valid, 0);
            chk("rst_hit_id", hit_id, 0);
`ifdef DETARB_HIT_COUNT_EN
            chk("rst_hit_count", hit_count, 0);
`endif
        end
    endtask

    // Caller sits at a negedge; waits for the next grant, checks owner,
    // number of CLEAR pulses seen before it and the burst length.
    task automatic wait_burst(input logic [3:0] eg, input string nm);
        int n   = 0;
        int nd  = 0;
        int len = 0;
        while (grant == 4'b0000 && n < 30) begin
            if (det_reset) nd++;
            tick();
            n++;
        end
        chk({nm, "_grant"}, grant, eg);
        chk({nm, "_clear_pulses"}, nd, 1);
        while (grant == eg && len < 30) begin
            chk({nm, "_no_dr_with_grant"}, det_reset, 0);
            len++;
            tick();
        end
        chk({nm, "_len"}, len, BURST);
    endtask

    // ---------------- behavioural reference model ----------------
    // pos: 0 idle, 1 clear, 2..BURST+1 feeding bit pos-2, BURST+2 release
    int m_pos, m_owner, m_last, m_hid, m_hcnt;
    bit m_ab, m_hv;

    function automatic void m_reset();
        m_pos = 0; m_owner = 0; m_last = NREQ - 1; m_hid = 0; m_hcnt = 0;
        m_ab = 1'b0; m_hv = 1'b0;
    endfunction

    function automatic void m_step(input logic rst, input logic [3:0] rq, input logic dz);
        bit run, win;
        if (rst) begin
            m_reset();
            return;
        end
        run = (m_pos >= 2) && (m_pos <= BURST + 1);
        win = (run && m_pos >= 3) || (m_pos == BURST + 2 && !m_ab);
        if (m_pos == 1) m_hcnt = 0;
        else if (m_hv && m_hcnt < 255) m_hcnt++;
        m_hid = m_owner;
        m_hv  = win && dz;
        if (m_pos == 0) begin
            for (int i = 1; i <= NREQ; i++) begin
                int c;
                c = (m_last + i) % NREQ;
                if (rq[c]) begin
                    m_owner = c;
                    m_pos   = 1;
                    break;
                end
            end
        end else if (m_pos == 1) begin
            m_pos = 2;
        end else if (run) begin
            if (!rq[m_owner]) begin
                m_ab = 1'b1; m_pos = BURST + 2;
            end else if (m_pos == BURST + 1) begin
                m_ab = 1'b0; m_pos = BURST + 2;
            end else begin
                m_pos++;
            end
        end else begin
            m_last = m_owner;
            m_pos  = 0;
        end
    endfunction

    typedef struct {
        logic [3:0] req;
        logic [3:0] bin;
        logic       dz;
        logic [3:0] g;
        logic       w;
        logic       dr;
        logic       b;
        logic       hv;
        logic [1:0] hid;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // owner 2, bits all ones; det_z pokes in IDLE, CLEAR, cnt0, cnt3, RELEASE
        tbl[0]  = '{4'b0100, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{4'b0100, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[2]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[3]  = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[4]  = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[6]  = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
        tbl[7]  = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[8]  = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[9]  = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[10] = '{4'b0100, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[11] = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        tbl[12] = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[13] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};

        // ---- table-driven single burst / hit window ----
        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            reset  = 1'b0;
            req    = tbl[i].req;
            bit_in = tbl[i].bin;
            det_z  = tbl[i].dz;
            @(negedge clk);
            chk("tbl_grant", grant, tbl[i].g);
            chk("tbl_det_w", det_w, tbl[i].w);
            chk("tbl_det_reset", det_reset, tbl[i].dr);
            chk("tbl_busy", busy, tbl[i].b);
            chk("tbl_hit_valid", hit_valid, tbl[i].hv);
            if (tbl[i].hv) chk("tbl_hit_id", hit_id, tbl[i].hid);
        end

        // ---- round-robin order with 1011 held ----
        do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b1011;
        @(negedge clk);
        wait_burst(4'b0001, "rr0");
        wait_burst(4'b0010, "rr1");
        wait_burst(4'b1000, "rr3");
        wait_burst(4'b0001, "rr0b");

        // ---- abort: req[2] drops at cnt=4 ----
        do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b1100;
        @(negedge clk);
        for (int n = 0; n < 30 && grant == 4'b0000; n++) tick();
        chk("abort_owner", grant, 4'b0100);
        repeat (3) tick();
        @(posedge clk);
        #1;
        req = 4'b1001;
        @(negedge clk);
        chk("abort_cycle_grant", grant, 4'b0100);
        tick();
        chk("abort_release_grant", grant, 4'b0000);
        chk("abort_release_busy", busy, 1);
        tick();
        chk("abort_idle_busy", busy, 0);
        wait_burst(4'b1000, "abort_next");

        // ---- mid-burst reset at cnt=5 ----
        do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b1111;
        @(negedge clk);
        wait_burst(4'b0001, "mr0");
        for (int n = 0; n < 30 && grant == 4'b0000; n++) tick();
        chk("mr_second_owner", grant, 4'b0010);
        repeat (4) tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mr_cnt5_grant", grant, 4'b0010);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mr_after_grant", grant, 4'b0000);
        chk("mr_after_busy", busy, 0);
`ifdef DETARB_HIT_COUNT_EN
        chk("mr_after_hit_count", hit_count, 0);
`endif
        wait_burst(4'b0001, "mr_regrant");

        // ---- randomized run against the reference model ----
        do_reset();
        m_reset();
        req = 4'b1111;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit       run;
            logic [3:0] rq;
            @(posedge clk);
            #1;
            rq = req;
            if ($urandom_range(0, 5) == 0) rq[$urandom_range(0, 3)] = ~rq[$urandom_range(0, 3)];
            if ($urandom_range(0, 9) == 0) rq[$urandom_range(0, 3)] = 1'b1;
            req    = rq;
            bit_in = 4'($urandom);
            det_z  = 1'($urandom_range(0, 1));
            reset  = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            run = (m_pos >= 2) && (m_pos <= BURST + 1);
            chk("rnd_grant", grant, run ? (32'd1 << m_owner) : 32'd0);
            chk("rnd_det_w", det_w, run ? 32'(bit_in[m_owner]) : 32'd0);
            chk("rnd_det_reset", det_reset, (m_pos == 1) ? 1 : 0);
            chk("rnd_busy", busy, (m_pos != 0) ? 1 : 0);
            chk("rnd_hit_valid", hit_valid, m_hv ? 1 : 0);
            if (m_hv) chk("rnd_hit_id", hit_id, m_hid);
`ifdef DETARB_HIT_COUNT_EN
            chk("rnd_hit_count", hit_count, m_hcnt);
`endif
            m_step(reset, req, det_z);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
